// File: rtl/md_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// operation encodings, FSM state encodings and the iteration count.
// The divider datapath is only present when MD_DIV_EN is defined.
package ParamDefine;

    // Default operand width; HI and LO are each this wide.
    localparam int MD_WIDTH = 32;

    // One shift-add or subtract-shift step per operand bit.
    localparam int MD_STEPS = MD_WIDTH;

    // mdOp encodings driven by the decoder.
    typedef enum logic [2:0] {
        MDOp_Mult  = 3'd0,
        MDOp_Multu = 3'd1,
        MDOp_Div   = 3'd2,
        MDOp_Divu  = 3'd3,
        MDOp_Mthi  = 3'd4,
        MDOp_Mtlo  = 3'd5
    } md_op_e;

    // Iterative FSM states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // True for the operations that treat operands as two's complement.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MDOp_Mult) || (op == MDOp_Div);
    endfunction

endpackage

// File: rtl/md_unit_divstep.sv
// One combinational restoring-divide step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep the
// difference when it does not borrow and emit the quotient bit.
module md_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    // Trial subtraction; since rem < divisor the borrow lands in the top bit.
    always_comb begin
        partial  = {rem, bit_in};
        diff     = partial - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit with architectural HI/LO.
// MULT/MULTU (and DIV/DIVU when MD_DIV_EN is defined) take one IDLE
// edge to latch, MD_STEPS CALC edges and one FIX edge; MTHI/MTLO write
// HI/LO in a single edge. Without MD_DIV_EN, DIV/DIVU starts are ignored.
//
// Handshake: start is a request sampled only at an edge where busy=0 and
// done=0; it is dropped (never queued) otherwise. busy stays high from the
// accepting edge until the FIX edge, and done pulses for the one cycle after
// FIX in which HI/LO first show the new result.
module md_unit
    import ParamDefine::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mdOp,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e          state;
    logic [CW-1:0]      count;

    // acc holds {upper, lower}: for multiply {partial product, multiplier},
    // for divide {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    // Multiplicand magnitude or divisor magnitude.
    logic [WIDTH-1:0]   opd;
    logic               s_a;
    logic               s_b;

    logic               accept;
    logic               lat_sa;
    logic               lat_sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;

`ifdef MD_DIV_EN
    logic               is_div;
    logic               b_zero;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH-1:0]   div_rem;
    logic               div_q;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    md_divstep #(
        .WIDTH (WIDTH)
    ) u_divstep (
        .rem      (acc[2*WIDTH-1:WIDTH]),
        .bit_in   (acc[WIDTH-1]),
        .divisor  (opd),
        .rem_next (div_rem),
        .q_bit    (div_q)
    );
`endif

    assign dbg_state = state;

    // Operand conditioning at latch time: signed ops become magnitude + sign.
    always_comb begin
        lat_sa = md_is_signed(mdOp) & inA[WIDTH-1];
        lat_sb = md_is_signed(mdOp) & inB[WIDTH-1];
        mag_a  = lat_sa ? -inA : inA;
        mag_b  = lat_sb ? -inB : inB;
        // A start in the done cycle is dropped along with starts while busy.
        accept = start && !busy && !done;
    end

    // One iteration step: shift-add for multiply, restoring step for divide.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
        acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MD_DIV_EN
        if (is_div) begin
            acc_next = {div_rem, acc[WIDTH-2:0], div_q};
        end
`endif
    end

    // Sign correction applied on the FIX edge.
    always_comb begin
        prod_fix = (s_a ^ s_b) ? -acc : acc;
`ifdef MD_DIV_EN
        quo_fix  = (s_a ^ s_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = s_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif
    end

    // Control FSM with registered busy/done and the HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            count <= '0;
            acc   <= '0;
            opd   <= '0;
            s_a   <= 1'b0;
            s_b   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
`ifdef MD_DIV_EN
            is_div <= 1'b0;
            b_zero <= 1'b0;
            raw_a  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        case (mdOp)
                            MDOp_Mult, MDOp_Multu: begin
                                acc   <= {{WIDTH{1'b0}}, mag_b};
                                opd   <= mag_a;
                                s_a   <= lat_sa;
                                s_b   <= lat_sb;
                                count <= '0;
                                busy  <= 1'b1;
                                state <= MD_CALC;
`ifdef MD_DIV_EN
                                is_div <= 1'b0;
`endif
                            end
`ifdef MD_DIV_EN
                            MDOp_Div, MDOp_Divu: begin
                                acc    <= {{WIDTH{1'b0}}, mag_a};
                                opd    <= mag_b;
                                s_a    <= lat_sa;
                                s_b    <= lat_sb;
                                is_div <= 1'b1;
                                b_zero <= (inB == '0);
                                raw_a  <= inA;
                                count  <= '0;
                                busy   <= 1'b1;
                                state  <= MD_CALC;
                            end
`endif
                            MDOp_Mthi: hi <= inA;
                            MDOp_Mtlo: lo <= inA;
                            default: ;
                        endcase
                    end
                end
                MD_CALC: begin
                    acc <= acc_next;
                    if (count == LAST) begin
                        state <= MD_FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                MD_FIX: begin
`ifdef MD_DIV_EN
                    if (is_div) begin
                        // Zero divisor bypasses sign fix: HI echoes the dividend.
                        if (b_zero) begin
                            hi <= raw_a;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else
`endif
                    begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    count <= '0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, hand-written multi-cycle
// sequences (ignored start, start in done cycle, reset abort) and random
// operations checked against an arithmetic reference model.
module tb_md_unit;
    import ParamDefine::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  mdOp;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int total;
    int bad;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        string       name;
    } vec_t;

    vec_t vecs[$];

    md_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mdOp      (mdOp),
        .inA       (inA),
        .inB       (inB),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] h, inout logic [31:0] l, output bit long_op);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] up;
`ifdef MD_DIV_EN
        logic signed [63:0] sq;
        logic signed [63:0] sr;
`endif
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        long_op = 1'b0;
        case (op)
            MDOp_Mult:  begin sp = sa * sb; {h, l} = sp; long_op = 1'b1; end
            MDOp_Multu: begin up = ua * ub; {h, l} = up; long_op = 1'b1; end
`ifdef MD_DIV_EN
            MDOp_Div: begin
                long_op = 1'b1;
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
            end
            MDOp_Divu: begin
                long_op = 1'b1;
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
            end
`endif
            MDOp_Mthi: h = a;
            MDOp_Mtlo: l = a;
            default: ;
        endcase
    endtask

    // Drive one operation and check it; optionally poke a second start at
    // CALC/FIX cycle poke_n (counted in edges after the accepting edge).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input bit use_exp,
                          input int poke_n, input logic [2:0] poke_op, input logic [31:0] poke_a,
                          input string name);
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] mh;
        logic [31:0] ml;
        bit long_op;
        bit busy_ok;
        bit hold_ok;
        int done_at;
        pre_hi = mdl_hi;
        pre_lo = mdl_lo;
        mh = mdl_hi;
        ml = mdl_lo;
        model(op, a, b, mh, ml, long_op);
        if (use_exp) begin
            mh = eh;
            ml = el;
        end
        @(negedge clk);
        start = 1'b1; mdOp = op; inA = a; inB = b;
        @(negedge clk);
        start = 1'b0;
        if (long_op) begin
            busy_ok = 1'b1;
            hold_ok = 1'b1;
            done_at = -1;
            for (int n = 0; n <= 34; n++) begin
                if (n > 0) @(negedge clk);
                if (n == poke_n + 1) start = 1'b0;
                if (done === 1'b1 && done_at < 0) done_at = n;
                if (n <= 32) begin
                    if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
                    if (hi !== pre_hi || lo !== pre_lo) hold_ok = 1'b0;
                end
                if (n == 33) begin
                    check({name, " busy_low_at_fix"}, 64'(busy), 64'd0);
                    check({name, " hi"}, 64'(hi), 64'(mh));
                    check({name, " lo"}, 64'(lo), 64'(ml));
                end
                if (n == 34) begin
                    check({name, " done_one_cycle"}, 64'(done), 64'd0);
                    check({name, " hilo_after"}, {hi, lo}, {mh, ml});
                end
                if (n == poke_n) begin
                    start = 1'b1; mdOp = poke_op; inA = poke_a; inB = 32'h3;
                end
            end
            check({name, " busy_window"}, 64'(busy_ok), 64'd1);
            check({name, " hilo_hold"}, 64'(hold_ok), 64'd1);
            check({name, " latency"}, 64'(done_at), 64'd33);
        end else begin
            check({name, " hi"}, 64'(hi), 64'(mh));
            check({name, " lo"}, 64'(lo), 64'(ml));
            check({name, " no_busy_done"}, {62'd0, busy, done}, 64'd0);
        end
        mdl_hi = mh;
        mdl_lo = ml;
    endtask

    initial begin
        bit saw_done;
        bit saw_busy;
        logic [2:0] rop;
        logic [31:0] ra;
        logic [31:0] rb;

        total = 0;
        bad = 0;
        mdl_hi = 0;
        mdl_lo = 0;
        start = 1'b0;
        mdOp = MDOp_Mult;
        inA = 0;
        inB = 0;

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        check("reset state", 64'(dbg_state), 64'(MD_IDLE));
        rst = 1'b0;

        // Directed vector table
        vecs.push_back('{MDOp_Mult,  32'h7FFF_FFF0, 32'h0000_0010, 32'h0000_0007, 32'hFFFF_FF00, "mult_basic"});
        vecs.push_back('{MDOp_Mthi,  32'hA5A5_A5A5, 32'h0,         32'hA5A5_A5A5, 32'hFFFF_FF00, "mthi"});
        vecs.push_back('{MDOp_Mtlo,  32'hDEAD_BEEF, 32'h0,         32'hA5A5_A5A5, 32'hDEAD_BEEF, "mtlo"});
        vecs.push_back('{MDOp_Mult,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_neg1"});
        vecs.push_back('{MDOp_Multu, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, "multu_ff"});
        vecs.push_back('{MDOp_Multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"});
        vecs.push_back('{MDOp_Mult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin"});
`ifdef MD_DIV_EN
        vecs.push_back('{MDOp_Div,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7"});
        vecs.push_back('{MDOp_Divu,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_7_2"});
        vecs.push_back('{MDOp_Divu,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, "divu_zero"});
        vecs.push_back('{MDOp_Div,   32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF, "div_zero_neg"});
        vecs.push_back('{MDOp_Div,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow"});
        vecs.push_back('{MDOp_Div,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, "div_pos_neg"});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, 1'b1,
                   -1, MDOp_Mult, 32'h0, vecs[i].name);
        end

        // Start while busy is dropped; operands are not re-latched
        run_op(MDOp_Mult, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'h0000_000F, 1'b1,
               5, MDOp_Mthi, 32'h0000_0001, "mult_busy_start");
        // Start in the done cycle is dropped
        run_op(MDOp_Multu, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, 1'b1,
               33, MDOp_Mtlo, 32'h0000_0055, "mult_done_start");

        // Reset in the middle of an operation aborts with no done
        run_op(MDOp_Mthi, 32'h1111_1111, 32'h0, 32'h0, 32'h0, 1'b0, -1, MDOp_Mult, 32'h0, "pre_rst_mthi");
        @(negedge clk);
`ifdef MD_DIV_EN
        start = 1'b1; mdOp = MDOp_Div; inA = 32'h0000_1000; inB = 32'h0000_0007;
`else
        start = 1'b1; mdOp = MDOp_Mult; inA = 32'h0000_1000; inB = 32'h0000_0007;
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hilo", {hi, lo}, 64'd0);
        check("abort state", 64'(dbg_state), 64'(MD_IDLE));
        saw_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        check("abort no_done", 64'(saw_done), 64'd0);
        mdl_hi = 0;
        mdl_lo = 0;

`ifndef MD_DIV_EN
        // Without the divider a DIV start does nothing at all
        run_op(MDOp_Mtlo, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0, 1'b0, -1, MDOp_Mult, 32'h0, "pre_div_mtlo");
        @(negedge clk);
        start = 1'b1; mdOp = MDOp_Div; inA = 32'h0000_0007; inB = 32'h0000_0002;
        @(negedge clk);
        start = 1'b0;
        saw_busy = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (busy !== 1'b0) saw_busy = 1'b1;
            if (done !== 1'b0) saw_done = 1'b1;
            @(negedge clk);
        end
        check("nodiv busy", 64'(saw_busy), 64'd0);
        check("nodiv done", 64'(saw_done), 64'd0);
        check("nodiv hilo", {hi, lo}, {mdl_hi, mdl_lo});
`endif

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'h0;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            run_op(rop, ra, rb, 32'h0, 32'h0, 1'b0, -1, MDOp_Mult, 32'h0, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
